// File: rtl/scr_ram_arbiter_if.sv
// Host write and display fetch channels shared between the screen RAM arbiter and its clients.
interface scr_ram_arbiter_if;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_gnt;
   logic          disp_rvalid;
   logic [DW-1:0] disp_rdata;

   modport slave (
      input  wr_valid, wr_addr, wr_data, disp_req, disp_addr,
      output wr_ready, disp_gnt, disp_rvalid, disp_rdata
   );

   modport master (
      output wr_valid, wr_addr, wr_data, disp_req, disp_addr,
      input  wr_ready, disp_gnt, disp_rvalid, disp_rdata
   );
endinterface

// File: rtl/scr_ram_arbiter.sv
// Screen RAM arbiter: display fetches win by default, queued host writes fill idle
// cycles and are forced through after STARVE_MAX consecutive denials.
module scr_ram_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   scr_ram_arbiter_if.slave  bus,
   output logic [15:0]       ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   output logic [4:0]        fifo_level,
   output logic              ovf
);
   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 8;
   localparam int unsigned LVL_W = 5;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      OWN_IDLE,
      OWN_DISP,
      OWN_HOST,
      OWN_FORCE
   } owner_e;

   wr_entry_t        queue [FIFO_DEPTH];
   wr_entry_t        head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] starve_cnt;
   logic [1:0]       gnt_pipe;
   owner_e           owner;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   assign fifo_empty   = (fifo_level == '0);
   assign head         = queue[rd_ptr];
   assign bus.wr_ready = !rst_n || (fifo_level < LVL_W'(FIFO_DEPTH));
   assign push         = rst_n && bus.wr_valid && bus.wr_ready;
   assign pop          = (owner == OWN_HOST) || (owner == OWN_FORCE);
   assign bus.disp_gnt = rst_n && (owner == OWN_DISP);

   // Per-cycle ownership of the RAM port
   always_comb begin
      owner = OWN_IDLE;
      if (!fifo_empty && (starve_cnt == CNT_W'(STARVE_MAX))) begin
         owner = OWN_FORCE;
      end else if (bus.disp_req) begin
         owner = OWN_DISP;
      end else if (!fifo_empty) begin
         owner = OWN_HOST;
      end
   end

   // Queue storage needs no reset; occupancy is tracked by the pointers and level
   always_ff @(posedge clk) begin
      if (push) begin
         queue[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_level      <= '0;
         starve_cnt      <= '0;
         ovf             <= 1'b0;
         ram_we          <= 1'b0;
         ram_addr        <= '0;
         ram_wdata       <= '0;
         gnt_pipe        <= '0;
         bus.disp_rvalid <= 1'b0;
         bus.disp_rdata  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
         if (bus.wr_valid && !bus.wr_ready) begin
            ovf <= 1'b1;
         end

         case (owner)
            OWN_DISP: begin
               ram_addr <= bus.disp_addr;
               ram_we   <= 1'b0;
               if (fifo_empty) begin
                  starve_cnt <= '0;
               end else if (starve_cnt != '1) begin
                  starve_cnt <= starve_cnt + CNT_W'(1);
               end
            end
            OWN_HOST, OWN_FORCE: begin
               ram_addr   <= head.addr;
               ram_wdata  <= head.data;
               ram_we     <= 1'b1;
               starve_cnt <= '0;
            end
            default: begin
               ram_we     <= 1'b0;
               starve_cnt <= '0;
            end
         endcase

         // RAM answers one cycle after the address, so capture two cycles after it
         gnt_pipe        <= {gnt_pipe[0], bus.disp_gnt};
         bus.disp_rvalid <= gnt_pipe[1];
         if (gnt_pipe[1]) begin
            bus.disp_rdata <= ram_rdata;
         end
      end
   end
endmodule

// File: tb/tb_scr_ram_arbiter.sv
// Directed bench for scr_ram_arbiter; RAM read data is a fixed function of the address.
module tb_scr_ram_arbiter;
   logic        clk;
   logic        rst_n;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic [4:0]  fifo_level;
   logic        ovf;
   int          checks;
   int          errors;

   scr_ram_arbiter_if bus ();

   scr_ram_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata),
      .fifo_level (fifo_level),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM read model: data = lo ^ hi ^ 0x78 (0x0123 -> 0x5A)
   always @(posedge clk) ram_rdata <= ram_addr[7:0] ^ ram_addr[15:8] ^ 8'h78;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.disp_req = 1'b1;
      bus.disp_addr = 16'h0123;
      step();
      step();
      @(negedge clk);
      checks++; if (bus.disp_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", bus.disp_gnt); end
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b exp 1", bus.wr_ready); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
      checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL rst_ram_addr got %h exp 0000", ram_addr); end
      checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL rst_ram_wdata got %h exp 00", ram_wdata); end
      checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", bus.disp_rvalid); end
      checks++; if (bus.disp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", bus.disp_rdata); end
      step();
      bus.disp_req = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_disp_read();
      bus.disp_req = 1'b1;
      bus.disp_addr = 16'h0123;
      @(negedge clk);
      checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt_c0 got %b exp 1", bus.disp_gnt); end
      step();
      bus.disp_req = 1'b0;
      checks++; if (ram_addr !== 16'h0123) begin errors++; $display("FAIL rd_addr_c1 got %h exp 0123", ram_addr); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_we_c1 got %b exp 0", ram_we); end
      checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_c1 got %b exp 0", bus.disp_rvalid); end
      step();
      checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_c2 got %b exp 0", bus.disp_rvalid); end
      step();
      checks++; if (bus.disp_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid_c3 got %b exp 1", bus.disp_rvalid); end
      checks++; if (bus.disp_rdata !== 8'h5A) begin errors++; $display("FAIL rd_rdata_c3 got %h exp 5a", bus.disp_rdata); end
      step();
      checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_c4 got %b exp 0", bus.disp_rvalid); end
      checks++; if (bus.disp_rdata !== 8'h5A) begin errors++; $display("FAIL rd_rdata_hold got %h exp 5a", bus.disp_rdata); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_rd [3];
      exp_rd[0] = 8'h5A;
      exp_rd[1] = 8'h5D;
      exp_rd[2] = 8'h5C;
      for (int i = 0; i < 7; i++) begin
         bus.disp_req = (i < 3);
         bus.disp_addr = 16'h0123 + 16'(i);
         @(negedge clk);
         checks++; if (bus.disp_gnt !== (i < 3)) begin errors++; $display("FAIL b2b_gnt c%0d got %b", i, bus.disp_gnt); end
         checks++; if (bus.disp_rvalid !== (i >= 3 && i < 6)) begin errors++; $display("FAIL b2b_rvalid c%0d got %b", i, bus.disp_rvalid); end
         if (i >= 3 && i < 6) begin
            checks++; if (bus.disp_rdata !== exp_rd[i-3]) begin errors++; $display("FAIL b2b_rdata c%0d got %h exp %h", i, bus.disp_rdata, exp_rd[i-3]); end
         end
         step();
      end
      bus.disp_req = 1'b0;
   endtask

   task automatic test_host_writes();
      logic [7:0] wd [3];
      logic [4:0] exp_lvl [6];
      wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
      exp_lvl[0] = 5'd0; exp_lvl[1] = 5'd1; exp_lvl[2] = 5'd1;
      exp_lvl[3] = 5'd1; exp_lvl[4] = 5'd0; exp_lvl[5] = 5'd0;
      bus.disp_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.wr_valid = (i < 3);
         bus.wr_addr = 16'h8000 + 16'(i);
         bus.wr_data = (i < 3) ? wd[i] : 8'h00;
         @(negedge clk);
         checks++; if (fifo_level !== exp_lvl[i]) begin errors++; $display("FAIL wr_level c%0d got %0d exp %0d", i, fifo_level, exp_lvl[i]); end
         checks++; if (ram_we !== (i >= 2 && i <= 4)) begin errors++; $display("FAIL wr_we c%0d got %b", i, ram_we); end
         if (i >= 2 && i <= 4) begin
            checks++; if (ram_addr !== 16'h8000 + 16'(i - 2)) begin errors++; $display("FAIL wr_addr c%0d got %h", i, ram_addr); end
            checks++; if (ram_wdata !== wd[i-2]) begin errors++; $display("FAIL wr_data c%0d got %h exp %h", i, ram_wdata, wd[i-2]); end
         end
         step();
      end
   endtask

   task automatic test_starve();
      int grants;
      bit found;
      grants = 0;
      found = 1'b0;
      bus.disp_req = 1'b1;
      bus.disp_addr = 16'h0200;
      bus.wr_valid = 1'b1;
      bus.wr_addr = 16'h9000;
      bus.wr_data = 8'h44;
      @(negedge clk);
      checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL stv_gnt_push got %b exp 1", bus.disp_gnt); end
      step();
      bus.wr_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.disp_gnt !== 1'b1) begin
            found = 1'b1;
            break;
         end
         grants++;
         step();
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL stv_force_seen got %b exp 1", found); end
      checks++; if (grants != 16) begin errors++; $display("FAIL stv_grants got %0d exp 16", grants); end
      checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL stv_level got %0d exp 1", fifo_level); end
      step();
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL stv_we got %b exp 1", ram_we); end
      checks++; if (ram_addr !== 16'h9000) begin errors++; $display("FAIL stv_addr got %h exp 9000", ram_addr); end
      checks++; if (ram_wdata !== 8'h44) begin errors++; $display("FAIL stv_data got %h exp 44", ram_wdata); end
      @(negedge clk);
      checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL stv_resume got %b exp 1", bus.disp_gnt); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL stv_drained got %0d exp 0", fifo_level); end
      step();
      bus.disp_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_overflow();
      bus.disp_req = 1'b1;
      bus.disp_addr = 16'h0300;
      for (int i = 0; i < 5; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr = 16'hA000 + 16'(i);
         bus.wr_data = 8'(i);
         @(negedge clk);
         checks++; if (bus.wr_ready !== (i < 4)) begin errors++; $display("FAIL ovf_ready c%0d got %b", i, bus.wr_ready); end
         checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early c%0d got %b exp 0", i, ovf); end
         step();
      end
      bus.wr_valid = 1'b0;
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
      checks++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
      for (int i = 0; i < 3; i++) step();
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL ovf_rst_ready got %b exp 1", bus.wr_ready); end
      checks++; if (bus.disp_gnt !== 1'b0) begin errors++; $display("FAIL ovf_rst_gnt got %b exp 0", bus.disp_gnt); end
      step();
      rst_n = 1'b1;
      bus.disp_req = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_rst_level got %0d exp 0", fifo_level); end
      step();
   endtask

   task automatic test_reset_mid();
      bus.disp_req = 1'b1;
      bus.disp_addr = 16'h0123;
      bus.wr_valid = 1'b1;
      bus.wr_addr = 16'hB000;
      bus.wr_data = 8'h55;
      step();
      bus.wr_addr = 16'hB001;
      bus.wr_data = 8'h66;
      step();
      bus.wr_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b exp 1", bus.disp_gnt); end
      checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL mid_level got %0d exp 2", fifo_level); end
      step();
      rst_n = 1'b0;
      bus.disp_req = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid c%0d got %b exp 0", i, bus.disp_rvalid); end
         checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_we c%0d got %b exp 0", i, ram_we); end
         checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL mid_level c%0d got %0d exp 0", i, fifo_level); end
         step();
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_addr = 16'h0000;
      bus.wr_data = 8'h00;
      bus.disp_req = 1'b0;
      bus.disp_addr = 16'h0000;
      test_reset();
      test_disp_read();
      test_back_to_back();
      test_host_writes();
      test_starve();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
